// File: rtl/m68k_bus_pkg.sv
// Shared types and helpers for the 68000 bus arbiter: FSM encoding,
// requester count and the round-robin winner selection.
package m68k_bus_pkg;

    localparam int NREQ = 2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ABORT,
        WAIT_BUS,
        OWN,
        RELEASE
    } state_t;

    // Counter width, never narrower than one bit.
    function automatic int clog2(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // The pointer wins if it is requesting; otherwise the other requester does.
    function automatic logic rr_select(input logic [NREQ-1:0] req, input logic ptr);
        return req[ptr] ? ptr : ~ptr;
    endfunction

endpackage

// File: rtl/m68k_bus_arbiter_sync.sv
// Multi-flop synchronizer for one asynchronous active-low 68000 bus strobe.
// It resets to 1, so after reset the strobe reads as negated.
module m68k_bus_arbiter_sync
    import m68k_bus_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk12,
    input  logic rstn,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] stages_q;

    always_ff @(posedge clk12 or negedge rstn) begin
        if (!rstn) begin
            stages_q <= '1;
        end else begin
            stages_q <= (stages_q << 1) | STAGES'(async_in);
        end
    end

    assign sync_out = stages_q[STAGES-1];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// BRn/BGn/BGACKn arbiter that lends the 68000 bus to two DMA requesters
// in round-robin order, with a forced release after MAX_HOLD cycles.
module m68k_bus_arbiter
    import m68k_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_HOLD    = 1024,
    parameter int TURNAROUND  = 2
) (
    input  logic            clk12,
    input  logic            rstn,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] gnt,
    output logic            dma_oe,
    output logic            timeout,
    input  logic            ASn,
    input  logic            DTACKn,
    input  logic            BGn,
    output logic            BRn,
    output logic            BGACKn
);

    localparam int HOLD_W = clog2(MAX_HOLD + 1);
    localparam int TURN_W = clog2(TURNAROUND + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
    localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURNAROUND);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic              brn_q, brn_d;
    logic              bgackn_q, bgackn_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              dma_oe_q, dma_oe_d;
    logic              timeout_q, timeout_d;
    logic              as_s, dtack_s, bg_s;

    m68k_bus_arbiter_sync #(.STAGES(SYNC_STAGES)) u_sync_as (
        .clk12(clk12), .rstn(rstn), .async_in(ASn), .sync_out(as_s)
    );

    m68k_bus_arbiter_sync #(.STAGES(SYNC_STAGES)) u_sync_dtack (
        .clk12(clk12), .rstn(rstn), .async_in(DTACKn), .sync_out(dtack_s)
    );

    m68k_bus_arbiter_sync #(.STAGES(SYNC_STAGES)) u_sync_bg (
        .clk12(clk12), .rstn(rstn), .async_in(BGn), .sync_out(bg_s)
    );

    always_ff @(posedge clk12 or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            ptr_q     <= 1'b0;
            hold_q    <= '0;
            turn_q    <= '0;
            brn_q     <= 1'b1;
            bgackn_q  <= 1'b1;
            gnt_q     <= '0;
            dma_oe_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            brn_q     <= brn_d;
            bgackn_q  <= bgackn_d;
            gnt_q     <= gnt_d;
            dma_oe_q  <= dma_oe_d;
            timeout_q <= timeout_d;
        end
    end

    // Every output is registered, so each one changes on the edge that enters the state.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        brn_d     = brn_q;
        bgackn_d  = bgackn_q;
        gnt_d     = gnt_q;
        dma_oe_d  = dma_oe_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (turn_q != '0) begin
                    turn_d = turn_q - TURN_W'(1);
                end else if (req != '0) begin
                    owner_d = rr_select(req, ptr_q);
                    state_d = REQ;
                    brn_d   = 1'b0;
                end
            end
            REQ: begin
                if (!req[owner_q]) begin
                    state_d = ABORT;
                    brn_d   = 1'b1;
                end else if (!bg_s) begin
                    state_d = WAIT_BUS;
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            WAIT_BUS: begin
                // The CPU's last cycle must have fully ended before the bus is taken.
                if (as_s && dtack_s && bgackn_q) begin
                    state_d        = OWN;
                    bgackn_d       = 1'b0;
                    gnt_d          = '0;
                    gnt_d[owner_q] = 1'b1;
                    dma_oe_d       = 1'b1;
                    hold_d         = '0;
                end
            end
            OWN: begin
                brn_d = 1'b1;
                if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
                if (done[owner_q] || !req[owner_q]) begin
                    state_d  = RELEASE;
                    gnt_d    = '0;
                    dma_oe_d = 1'b0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = RELEASE;
                    gnt_d     = '0;
                    dma_oe_d  = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            RELEASE: begin
                bgackn_d = 1'b1;
                ptr_d    = ~owner_q;
                turn_d   = TURN_LOAD;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign BRn     = brn_q;
    assign BGACKn  = bgackn_q;
    assign gnt     = gnt_q;
    assign dma_oe  = dma_oe_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Bench for m68k_bus_arbiter: a per-cycle vector table for the grant and
// bus-busy handshakes, plus hand sequences for contention, timeout, abort and async reset.
module tb_m68k_bus_arbiter;

    localparam int MAX_HOLD   = 16;
    localparam int TURNAROUND = 2;

    logic       clk12   = 1'b0;
    logic       rstn    = 1'b0;
    logic [1:0] req     = 2'b00;
    logic [1:0] done    = 2'b00;
    logic       as_n    = 1'b1;
    logic       dtack_n = 1'b1;
    logic       bg_n    = 1'b1;
    logic [1:0] gnt;
    logic       dma_oe;
    logic       timeout;
    logic       br_n;
    logic       bgack_n;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Expected outputs are packed as {BRn, BGACKn, gnt[1:0], dma_oe, timeout}.
    typedef struct {
        logic [1:0] req;
        logic [1:0] done;
        logic       as_n;
        logic       dtack_n;
        logic       bg_n;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk12 = ~clk12;

    m68k_bus_arbiter #(
        .SYNC_STAGES(2),
        .MAX_HOLD(MAX_HOLD),
        .TURNAROUND(TURNAROUND)
    ) dut (
        .clk12(clk12),
        .rstn(rstn),
        .req(req),
        .done(done),
        .gnt(gnt),
        .dma_oe(dma_oe),
        .timeout(timeout),
        .ASn(as_n),
        .DTACKn(dtack_n),
        .BGn(bg_n),
        .BRn(br_n),
        .BGACKn(bgack_n)
    );

    function automatic logic [5:0] outs();
        return {br_n, bgack_n, gnt, dma_oe, timeout};
    endfunction

    task automatic tick();
        @(posedge clk12);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req     = v.req;
        done    = v.done;
        as_n    = v.as_n;
        dtack_n = v.dtack_n;
        bg_n    = v.bg_n;
    endtask

    task automatic add_vec(input logic [1:0] r, input logic [1:0] d, input logic a,
                           input logic dt, input logic b, input logic [5:0] e);
        vec_t v;
        v.req = r; v.done = d; v.as_n = a; v.dtack_n = dt; v.bg_n = b; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic reset_dut();
        rstn = 1'b0; req = 2'b00; done = 2'b00;
        as_n = 1'b1; dtack_n = 1'b1; bg_n = 1'b1;
        repeat (2) @(posedge clk12);
        #1;
        checkOutput("reset_state", outs(), 6'b1_1_00_0_0);
        rstn = 1'b1;
    endtask

    task automatic wait_brn(input logic level, output int n);
        n = 0;
        while (br_n !== level && n < 64) begin
            tick();
            n++;
        end
        checkOutput("wait_brn", br_n, level);
    endtask

    task automatic wait_bgackn(input logic level, output int n);
        n = 0;
        while (bgack_n !== level && n < 64) begin
            tick();
            n++;
        end
        checkOutput("wait_bgackn", bgack_n, level);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int held;
        bit ok;
        logic [1:0] order [3];

        // Single grant, then requester 1 against a busy CPU bus.
        for (int i = 0; i < 3; i++) add_vec(2'b01, 2'b00, 1, 1, 1, 6'b0_1_00_0_0);
        for (int i = 0; i < 3; i++) add_vec(2'b01, 2'b00, 1, 1, 0, 6'b0_1_00_0_0);
        add_vec(2'b01, 2'b00, 1, 1, 0, 6'b0_0_01_1_0);
        add_vec(2'b01, 2'b00, 1, 1, 1, 6'b1_0_01_1_0);
        add_vec(2'b01, 2'b01, 1, 1, 1, 6'b1_0_00_0_0);
        add_vec(2'b00, 2'b00, 1, 1, 1, 6'b1_1_00_0_0);
        for (int i = 0; i < 2; i++) add_vec(2'b10, 2'b00, 1, 1, 1, 6'b1_1_00_0_0);
        add_vec(2'b10, 2'b00, 1, 1, 1, 6'b0_1_00_0_0);
        for (int i = 0; i < 6; i++) add_vec(2'b10, 2'b00, 0, 0, 0, 6'b0_1_00_0_0);
        add_vec(2'b10, 2'b00, 1, 0, 0, 6'b0_1_00_0_0);
        for (int i = 0; i < 2; i++) add_vec(2'b10, 2'b00, 1, 1, 0, 6'b0_1_00_0_0);
        add_vec(2'b10, 2'b00, 1, 1, 0, 6'b0_0_10_1_0);
        add_vec(2'b10, 2'b00, 1, 1, 1, 6'b1_0_10_1_0);
        add_vec(2'b10, 2'b01, 1, 1, 1, 6'b1_0_10_1_0);
        add_vec(2'b00, 2'b00, 1, 1, 1, 6'b1_0_00_0_0);
        add_vec(2'b00, 2'b00, 1, 1, 1, 6'b1_1_00_0_0);

        reset_dut();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Contention: both requesting, grants alternate with a fixed turnaround gap.
        reset_dut();
        order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01;
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            wait_brn(1'b0, n);
            if (i > 0) checkOutput($sformatf("turnaround_gap%0d", i), 8'(n), 8'd3);
            bg_n = 1'b0;
            wait_bgackn(1'b0, n);
            checkOutput($sformatf("contention_gnt%0d", i), gnt, order[i]);
            bg_n = 1'b1;
            done = order[i];
            tick();
            done = 2'b00;
            checkOutput($sformatf("release%0d", i), {gnt, dma_oe, bgack_n}, 4'b00_0_0);
            wait_bgackn(1'b1, n);
        end
        req = 2'b00;

        // Timeout: requester 0 never pulses done.
        reset_dut();
        req = 2'b01;
        wait_brn(1'b0, n);
        bg_n = 1'b0;
        wait_bgackn(1'b0, n);
        checkOutput("timeout_own_gnt", gnt, 2'b01);
        bg_n = 1'b1;
        held = 0;
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            tick();
            if (gnt === 2'b01 && timeout === 1'b0) held++;
        end
        checkOutput("hold_cycles", 8'(held), 8'(MAX_HOLD - 1));
        tick();
        checkOutput("timeout_pulse", {timeout, gnt, dma_oe}, 4'b1_00_0);
        tick();
        checkOutput("timeout_clear", {timeout, bgack_n}, 2'b0_1);
        req = 2'b11;
        wait_brn(1'b0, n);
        bg_n = 1'b0;
        wait_bgackn(1'b0, n);
        checkOutput("ptr_after_timeout", gnt, 2'b10);
        bg_n = 1'b1;
        done = 2'b10;
        req  = 2'b00;
        tick();
        done = 2'b00;
        wait_bgackn(1'b1, n);

        // Abort: request withdrawn before the CPU grants.
        reset_dut();
        req = 2'b01;
        wait_brn(1'b0, n);
        req = 2'b00;
        n = 0;
        while (br_n !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        checkOutput("abort_brn_release", {7'd0, (br_n === 1'b1 && n <= 2)}, 8'd1);
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (gnt !== 2'b00 || timeout !== 1'b0 || bgack_n !== 1'b1 || br_n !== 1'b1) ok = 1'b0;
        end
        checkOutput("abort_no_grant", {7'd0, ok}, 8'd1);

        // Asynchronous reset while the DMA side owns the bus.
        reset_dut();
        req = 2'b01;
        wait_brn(1'b0, n);
        bg_n = 1'b0;
        wait_bgackn(1'b0, n);
        checkOutput("own_before_reset", {bgack_n, gnt, dma_oe}, 4'b0_01_1);
        bg_n = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("async_reset_outputs", outs(), 6'b1_1_00_0_0);
        #2;
        rstn = 1'b1;
        req  = 2'b10;
        tick();
        wait_brn(1'b0, n);
        bg_n = 1'b0;
        wait_bgackn(1'b0, n);
        checkOutput("post_reset_gnt", gnt, 2'b10);
        bg_n = 1'b1;
        done = 2'b10;
        req  = 2'b00;
        tick();
        done = 2'b00;
        wait_bgackn(1'b1, n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
